// File: rtl/button_pkg.sv
// Shared types and default constants for the button pulse generator.
package button_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } btn_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 20;
    localparam int DEF_HOLD_CYCLES     = 500;
    localparam int DEF_REPEAT_CYCLES   = 200;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for the raw active-low button; resets to released (1).
module btn_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic btn_sync_n
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= btn_n;
            sync_q <= meta_q;
        end
    end

    assign btn_sync_n = sync_q;

endmodule

// File: rtl/button_pulse_gen.sv
// Debounced one-pulse-per-press enable generator for the 4-bit counter.
// Optional auto-repeat while held is built when AUTO_REPEAT_EN is defined.
module button_pulse_gen
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic enable_pulse,
    output logic btn_level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("button_pulse_gen: cycle parameters must be >= 1");
    end

    logic       btn_sync_n;
    logic       press_s_q, press_s_d;
    btn_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       enable_pulse_q, enable_pulse_d;
    logic       btn_level_q, btn_level_d;
    logic       press_fire;
    logic       rep_fire;

    btn_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_n      (btn_n),
        .btn_sync_n (btn_sync_n)
    );

    // press_s is a registered, active-high copy of the synchronised button.
    assign press_s_d = ~btn_sync_n;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        btn_level_d = btn_level_q;
        press_fire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_s_q) begin
                    state_d = DEB_PRESS;
                    cnt_d   = '0;
                end
            end
            DEB_PRESS: begin
                if (!press_s_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = HELD;
                    cnt_d       = '0;
                    btn_level_d = 1'b1;
                    press_fire  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!press_s_q) begin
                    state_d = DEB_REL;
                    cnt_d   = '0;
                end
            end
            DEB_REL: begin
                if (press_s_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    btn_level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                btn_level_d = 1'b0;
            end
        endcase
    end

`ifdef AUTO_REPEAT_EN
    localparam int REP_W = $clog2(max2(HOLD_CYCLES, REPEAT_CYCLES) + 1);
    localparam logic [REP_W-1:0] HOLD_LAST = REP_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_phase_q, rep_phase_d;

    // Counter only advances while continuously held; any exit from HELD clears it,
    // so every entry into HELD starts a fresh HOLD_CYCLES phase.
    always_comb begin
        rep_cnt_d   = '0;
        rep_phase_d = 1'b0;
        rep_fire    = 1'b0;
        if (state_q == HELD && press_s_q) begin
            rep_phase_d = rep_phase_q;
            if (!rep_phase_q) begin
                if (rep_cnt_q == HOLD_LAST) begin
                    rep_fire    = 1'b1;
                    rep_phase_d = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
            end else if (rep_cnt_q == REP_LAST) begin
                rep_fire = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Guard keeps the counter enable from ever being high two cycles running.
    assign enable_pulse_d = (press_fire | rep_fire) & ~enable_pulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_s_q      <= 1'b0;
            state_q        <= IDLE;
            cnt_q          <= '0;
            enable_pulse_q <= 1'b0;
            btn_level_q    <= 1'b0;
        end else begin
            press_s_q      <= press_s_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            enable_pulse_q <= enable_pulse_d;
            btn_level_q    <= btn_level_d;
        end
    end

    assign enable_pulse = enable_pulse_q;
    assign btn_level    = btn_level_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed bench for button_pulse_gen with DEBOUNCE=4, HOLD=8, REPEAT=4.
module tb_button_pulse_gen;

    localparam int D = 4;
`ifdef AUTO_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic btn_n;
    logic enable_pulse;
    logic btn_level;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pulse_cnt = 0;
    int consec   = 0;
    logic prev_pulse = 1'b0;
    logic [3:0] cnt4;

    button_pulse_gen #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (8),
        .REPEAT_CYCLES   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_n        (btn_n),
        .enable_pulse (enable_pulse),
        .btn_level    (btn_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (enable_pulse) pulse_cnt++;
        if (enable_pulse && prev_pulse) consec++;
        prev_pulse = enable_pulse;
    end

    // Model of the downstream 4-bit counter driven by the pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt4 <= 4'd0;
        else if (enable_pulse) cnt4 <= cnt4 + 4'd1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic at(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e, r, p, f, base;
        rst_n = 1'b0;
        btn_n = 1'b1;
        at(3);
        chk("reset_pulse", enable_pulse, 0);
        chk("reset_level", btn_level, 0);
        rst_n = 1'b1;
        at(6);

        // 1: clean press and release
        base = pulse_cnt;
        e = cyc + 1;
        btn_n = 1'b0;
        at(e + 6);
        chk("s1_pulse_early", enable_pulse, 0);
        chk("s1_level_early", btn_level, 0);
        at(e + 7);
        chk("s1_pulse", enable_pulse, 1);
        chk("s1_level", btn_level, 1);
        at(e + 8);
        chk("s1_pulse_width", enable_pulse, 0);
        at(e + 39);
        btn_n = 1'b1;
        r = e + 40;
        at(r + 6);
        chk("s1_level_hold", btn_level, 1);
        at(r + 7);
        chk("s1_level_fall", btn_level, 0);
        chk("s1_no_rel_pulse", enable_pulse, 0);
        at(r + 10);
        chk("s1_pulse_count", pulse_cnt - base, REP ? 8 : 1);

        // 2: bouncy press
        at(cyc + 3);
        base = pulse_cnt;
        for (int i = 0; i < 3; i++) begin
            btn_n = 1'b0;
            at(cyc + 2);
            btn_n = 1'b1;
            at(cyc + 2);
        end
        btn_n = 1'b0;
        f = cyc + 1;
        at(f + 6);
        chk("s2_pulse_early", enable_pulse, 0);
        at(f + 7);
        chk("s2_pulse", enable_pulse, 1);
        at(f + 8);
        chk("s2_pulse_count", pulse_cnt - base, 1);
        btn_n = 1'b1;
        r = f + 9;
        at(r + 8);
        chk("s2_level_rel", btn_level, 0);
        chk("s2_pulse_count_rel", pulse_cnt - base, 1);

        // 3: short glitch
        at(cyc + 3);
        base = pulse_cnt;
        e = cyc + 1;
        btn_n = 1'b0;
        at(e + 2);
        btn_n = 1'b1;
        at(e + 5);
        chk("s3_level_mid", btn_level, 0);
        at(e + 12);
        chk("s3_level", btn_level, 0);
        chk("s3_pulse_count", pulse_cnt - base, 0);

        // 4: release bounce while held
        base = pulse_cnt;
        e = cyc + 1;
        btn_n = 1'b0;
        at(e + 8);
        chk("s4_level_held", btn_level, 1);
        btn_n = 1'b1;
        at(e + 10);
        btn_n = 1'b0;
        at(e + 12);
        chk("s4_level_bounce", btn_level, 1);
        at(e + 14);
        chk("s4_level_after", btn_level, 1);
        at(e + 15);
        btn_n = 1'b1;
        r = e + 16;
        at(r + 8);
        chk("s4_level_rel", btn_level, 0);
        chk("s4_pulse_count", pulse_cnt - base, 1);

        // 5: reset during press debounce, button kept down
        at(cyc + 3);
        base = pulse_cnt;
        e = cyc + 1;
        btn_n = 1'b0;
        at(e + 4);
        rst_n = 1'b0;
        #1;
        chk("s5_rst_pulse", enable_pulse, 0);
        chk("s5_rst_level", btn_level, 0);
        chk("s5_rst_cnt4", cnt4, 0);
        at(e + 7);
        rst_n = 1'b1;
        e = e + 8;
        at(e + 6);
        chk("s5_pulse_early", enable_pulse, 0);
        at(e + 7);
        chk("s5_pulse", enable_pulse, 1);
        chk("s5_cnt4_before", cnt4, 0);
        at(e + 8);
        chk("s5_cnt4_after", cnt4, 1);
        chk("s5_pulse_count", pulse_cnt - base, 1);
        btn_n = 1'b1;
        r = e + 9;
        at(r + 7);
        chk("s5_level_rel", btn_level, 0);

        // 6: long hold, auto-repeat cadence when built in
        at(cyc + 3);
        base = pulse_cnt;
        e = cyc + 1;
        btn_n = 1'b0;
        p = e + 7;
        for (int k = 0; k < 32; k++) begin
            at(p + k);
            chk($sformatf("s6_pulse_k%0d", k), enable_pulse,
                (k == 0 || (REP && k >= 8 && ((k - 8) % 4) == 0)) ? 1 : 0);
            if (k == 28) btn_n = 1'b1;
        end
        r = p + 29;
        at(r + 7);
        chk("s6_level_rel", btn_level, 0);
        at(r + 8);
        chk("s6_pulse_count", pulse_cnt - base, REP ? 7 : 1);

        chk("never_consecutive", consec, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
